// File: rtl/path_tracer.sv
// Walks a Dijkstra previous vector from destination back to source through the
// custom-instruction interface, then streams the path source-first on valid/ready.
module path_tracer #(
    parameter int MAX_NODES = 1024,
    parameter int INDEX_WIDTH = 10,
    parameter logic [INDEX_WIDTH-1:0] UNREACHABLE = {INDEX_WIDTH{1'b1}}
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   trace_start,
    input  logic [15:0]            source,
    input  logic [15:0]            destination,
    input  logic [15:0]            number_of_nodes,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             error_code,
    output logic [INDEX_WIDTH:0]   path_length,
    output logic                   di_start,
    output logic [7:0]             di_select_n,
    output logic [31:0]            di_dataa,
    output logic [31:0]            di_datab,
    output logic                   di_clock_enable,
    input  logic [31:0]            di_result,
    input  logic                   di_ready,
    output logic                   node_valid,
    output logic [15:0]            node_index,
    output logic                   node_last,
    input  logic                   node_ready
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        ISSUE  = 3'd2,
        WAIT   = 3'd3,
        PUSH   = 3'd4,
        EMIT   = 3'd5,
        FINISH = 3'd6
    } state_t;

    localparam logic [INDEX_WIDTH:0] SP_ONE = {{INDEX_WIDTH{1'b0}}, 1'b1};
    localparam logic [16:0] MAX_NODES_W = 17'(MAX_NODES);

    state_t                 state_r, state_s;
    logic [15:0]            src_r, src_s, dst_r, dst_s, nn_r, nn_s, cur_r, cur_s;
    logic [INDEX_WIDTH-1:0] prev_r, prev_s;
    logic [INDEX_WIDTH:0]   sp_r, sp_s, plen_r, plen_s, rd_full_s;
    logic [1:0]             err_r, err_s;
    logic                   push_s;
    logic [INDEX_WIDTH-1:0] push_data_s, rd_addr_s;
    logic                   busy_r, done_r, di_start_r, di_ce_r;
    logic                   node_valid_r, node_last_r;
    logic [INDEX_WIDTH-1:0] node_index_r;
    logic [INDEX_WIDTH-1:0] stack_r [MAX_NODES];

    // Next-state and datapath update for the trace FSM
    always_comb begin
        state_s     = state_r;
        src_s       = src_r;
        dst_s       = dst_r;
        nn_s        = nn_r;
        cur_s       = cur_r;
        prev_s      = prev_r;
        sp_s        = sp_r;
        err_s       = err_r;
        plen_s      = plen_r;
        push_s      = 1'b0;
        push_data_s = {INDEX_WIDTH{1'b0}};
        case (state_r)
            IDLE: begin
                if (trace_start) begin
                    src_s   = source;
                    dst_s   = destination;
                    nn_s    = number_of_nodes;
                    cur_s   = destination;
                    sp_s    = {(INDEX_WIDTH+1){1'b0}};
                    err_s   = 2'd0;
                    plen_s  = {(INDEX_WIDTH+1){1'b0}};
                    state_s = CHECK;
                end else begin
                    state_s = IDLE;
                end
            end
            CHECK: begin
                if ((src_r >= nn_r) || (dst_r >= nn_r) || ({1'b0, nn_r} > MAX_NODES_W)) begin
                    err_s   = 2'd3;
                    state_s = FINISH;
                end else begin
                    push_s      = 1'b1;
                    push_data_s = cur_r[INDEX_WIDTH-1:0];
                    sp_s        = sp_r + SP_ONE;
                    state_s     = (cur_r == src_r) ? FINISH : ISSUE;
                end
            end
            ISSUE: state_s = WAIT;
            WAIT: begin
                if (di_ready) begin
                    prev_s  = di_result[INDEX_WIDTH-1:0];
                    state_s = PUSH;
                end else begin
                    state_s = WAIT;
                end
            end
            PUSH: begin
                if (prev_r == UNREACHABLE) begin
                    err_s   = 2'd1;
                    state_s = FINISH;
                end else if ((16'(prev_r) >= nn_r) || (16'(sp_r) == nn_r)) begin
                    // More hops than nodes means the previous vector contains a cycle
                    err_s   = 2'd2;
                    state_s = FINISH;
                end else begin
                    push_s      = 1'b1;
                    push_data_s = prev_r;
                    sp_s        = sp_r + SP_ONE;
                    cur_s       = 16'(prev_r);
                    state_s     = (16'(prev_r) == src_r) ? FINISH : ISSUE;
                end
            end
            FINISH: begin
                state_s = ((err_r == 2'd0) && (sp_r != {(INDEX_WIDTH+1){1'b0}})) ? EMIT : IDLE;
            end
            EMIT: begin
                if (node_valid_r && node_ready) begin
                    sp_s    = sp_r - SP_ONE;
                    state_s = (sp_r == SP_ONE) ? IDLE : EMIT;
                end else begin
                    state_s = EMIT;
                end
            end
            default: state_s = IDLE;
        endcase
        if ((state_s == FINISH) && (state_r != FINISH)) begin
            plen_s = (err_s == 2'd0) ? sp_s : {(INDEX_WIDTH+1){1'b0}};
        end else begin
            plen_s = plen_s;
        end
        rd_full_s = sp_s - SP_ONE;
        rd_addr_s = rd_full_s[INDEX_WIDTH-1:0];
    end

    // State, datapath and registered outputs; the stack is read one cycle ahead
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            src_r        <= 16'd0;
            dst_r        <= 16'd0;
            nn_r         <= 16'd0;
            cur_r        <= 16'd0;
            prev_r       <= {INDEX_WIDTH{1'b0}};
            sp_r         <= {(INDEX_WIDTH+1){1'b0}};
            err_r        <= 2'd0;
            plen_r       <= {(INDEX_WIDTH+1){1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            di_start_r   <= 1'b0;
            di_ce_r      <= 1'b0;
            node_valid_r <= 1'b0;
            node_last_r  <= 1'b0;
            node_index_r <= {INDEX_WIDTH{1'b0}};
        end else begin
            state_r      <= state_s;
            src_r        <= src_s;
            dst_r        <= dst_s;
            nn_r         <= nn_s;
            cur_r        <= cur_s;
            prev_r       <= prev_s;
            sp_r         <= sp_s;
            err_r        <= err_s;
            plen_r       <= plen_s;
            busy_r       <= (state_s != IDLE);
            done_r       <= (state_s == FINISH);
            di_start_r   <= (state_s == ISSUE);
            di_ce_r      <= (state_s == WAIT);
            node_valid_r <= (state_s == EMIT);
            node_last_r  <= (state_s == EMIT) && (sp_s == SP_ONE);
            node_index_r <= stack_r[rd_addr_s];
        end
    end

    // Path stack storage
    always_ff @(posedge clock) begin
        if (push_s && !reset) begin
            stack_r[sp_r[INDEX_WIDTH-1:0]] <= push_data_s;
        end
    end

    assign busy            = busy_r;
    assign done            = done_r;
    assign error_code      = err_r;
    assign path_length     = plen_r;
    assign di_start        = di_start_r;
    assign di_select_n     = 8'd3;
    assign di_dataa        = {16'h0, cur_r};
    assign di_datab        = 32'd0;
    assign di_clock_enable = di_ce_r;
    assign node_valid      = node_valid_r;
    assign node_index      = 16'(node_index_r);
    assign node_last       = node_last_r;

endmodule

// File: tb/tb_path_tracer.sv
// Scoreboard bench for path_tracer: a previous-vector model answers interface
// reads, a reference walk predicts the streamed path and the result codes.
module tb_path_tracer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        trace_start = 1'b0;
    logic [15:0] source = 16'd0, destination = 16'd0, number_of_nodes = 16'd0;
    logic        busy, done, di_start, di_clock_enable, node_valid, node_last;
    logic [1:0]  error_code;
    logic [10:0] path_length;
    logic [7:0]  di_select_n;
    logic [31:0] di_dataa, di_datab;
    logic [31:0] di_result = 32'd0;
    logic        di_ready = 1'b0;
    logic [15:0] node_index;
    logic        node_ready = 1'b1;

    path_tracer dut (
        .clock(clock), .reset(reset), .trace_start(trace_start),
        .source(source), .destination(destination), .number_of_nodes(number_of_nodes),
        .busy(busy), .done(done), .error_code(error_code), .path_length(path_length),
        .di_start(di_start), .di_select_n(di_select_n), .di_dataa(di_dataa),
        .di_datab(di_datab), .di_clock_enable(di_clock_enable), .di_result(di_result),
        .di_ready(di_ready), .node_valid(node_valid), .node_index(node_index),
        .node_last(node_last), .node_ready(node_ready)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_fail = 0;
    int          txn_count = 0;
    bit          rnd_ready = 1'b0;
    logic [9:0]  prev_mem [1024];
    int          exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Interface model: answers each read after a random 0..2 cycle delay
    initial begin
        int wcnt = 0;
        int lat = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                di_ready = 1'b0;
                wcnt = 0;
            end else begin
                if (di_start) begin
                    txn_count++;
                    check("di_select_n", 32'(di_select_n), 32'd3);
                    check("di_datab", di_datab, 32'd0);
                end
                if (di_clock_enable) begin
                    if (wcnt >= lat) begin
                        di_ready = 1'b1;
                        di_result = {22'd0, prev_mem[di_dataa[9:0]]};
                        wcnt = 0;
                        lat = $urandom_range(0, 2);
                    end else begin
                        di_ready = 1'b0;
                        wcnt++;
                    end
                end else begin
                    di_ready = 1'b0;
                    wcnt = 0;
                end
            end
        end
    end

    // Stream monitor: pops the scoreboard on each transfer, checks stall stability
    initial begin
        bit          held_v = 1'b0;
        logic [15:0] held_idx = 16'd0;
        logic        held_last = 1'b0;
        int          e;
        forever begin
            @(negedge clock);
            node_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (reset) begin
                held_v = 1'b0;
            end else begin
                if (held_v) begin
                    check("stall_valid", 32'(node_valid), 32'd1);
                    check("stall_index", 32'(node_index), 32'(held_idx));
                    check("stall_last", 32'(node_last), 32'(held_last));
                end
                held_v = 1'b0;
                if (node_valid && node_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_node", 32'(node_index), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("node_index", 32'(node_index), 32'(e));
                        check("node_last", 32'(node_last), 32'(exp_q.size() == 0));
                    end
                end else if (node_valid) begin
                    held_v = 1'b1;
                    held_idx = node_index;
                    held_last = node_last;
                end
            end
        end
    end

    // Reference walk of the previous vector
    task automatic model_trace(input int src, input int dst, input int nn,
                               output int err, output int len, output int txn);
        int path [$];
        int cur;
        int prv;
        err = 0;
        txn = 0;
        if (src >= nn || dst >= nn || nn > 1024) begin
            err = 3;
        end else begin
            path.push_back(dst);
            cur = dst;
            while (err == 0 && cur != src) begin
                prv = int'(prev_mem[cur]);
                txn++;
                if (prv == 1023) err = 1;
                else if (prv >= nn || path.size() == nn) err = 2;
                else begin
                    path.push_back(prv);
                    cur = prv;
                end
            end
        end
        len = (err == 0) ? path.size() : 0;
        if (err == 0) for (int i = path.size() - 1; i >= 0; i--) exp_q.push_back(path[i]);
    endtask

    task automatic run_trace(input int src, input int dst, input int nn, input bit poke,
                             output int lat);
        int  err, len, txn;
        bit  seen;
        model_trace(src, dst, nn, err, len, txn);
        txn_count = 0;
        @(negedge clock);
        source = 16'(src);
        destination = 16'(dst);
        number_of_nodes = 16'(nn);
        trace_start = 1'b1;
        lat = 0;
        seen = 1'b0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            @(negedge clock);
            trace_start = 1'b0;
            lat++;
            if (done) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 32'd1);
        check("error_code", 32'(error_code), 32'(err));
        check("path_length", 32'(path_length), 32'(len));
        seen = 1'b0;
        for (int k = 0; k < 5000 && !seen; k++) begin
            @(negedge clock);
            if (k == 0) check("done_pulse", 32'(done), 32'd0);
            trace_start = poke && (k == 1);
            if (!busy && !trace_start) seen = 1'b1;
        end
        trace_start = 1'b0;
        check("idle_reached", 32'(seen), 32'd1);
        repeat (3) @(negedge clock);
        check("busy_after", 32'(busy), 32'd0);
        check("txn_count", 32'(txn_count), 32'(txn));
        check("stream_complete", 32'(exp_q.size()), 32'd0);
        check("error_held", 32'(error_code), 32'(err));
        check("length_held", 32'(path_length), 32'(len));
        exp_q.delete();
    endtask

    initial begin
        int lat;
        bit hit;
        for (int i = 0; i < 1024; i++) prev_mem[i] = 10'h3FF;
        repeat (3) @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error_code), 32'd0);
        check("rst_length", 32'(path_length), 32'd0);
        check("rst_di_start", 32'(di_start), 32'd0);
        check("rst_di_ce", 32'(di_clock_enable), 32'd0);
        check("rst_valid", 32'(node_valid), 32'd0);
        check("rst_last", 32'(node_last), 32'd0);
        reset = 1'b0;

        // Straight chain 0->1->2->3
        prev_mem[0] = 10'd0; prev_mem[1] = 10'd0; prev_mem[2] = 10'd1; prev_mem[3] = 10'd2;
        run_trace(0, 3, 4, 1'b0, lat);
        // Source equals destination
        run_trace(5, 5, 8, 1'b0, lat);
        // Unreachable destination
        prev_mem[3] = 10'h3FF;
        run_trace(0, 3, 4, 1'b0, lat);
        // Two-node loop
        prev_mem[2] = 10'd3; prev_mem[3] = 10'd2;
        run_trace(0, 3, 4, 1'b0, lat);
        // Out-of-range destination and oversized graph
        run_trace(0, 9, 4, 1'b0, lat);
        check("err3_latency", 32'(lat), 32'd2);
        run_trace(0, 1, 1025, 1'b0, lat);
        // Predecessor beyond node count
        prev_mem[3] = 10'd6;
        run_trace(0, 3, 4, 1'b0, lat);

        // Longer path under random backpressure, with a stray start while busy
        prev_mem[0] = 10'd9; prev_mem[9] = 10'd3; prev_mem[3] = 10'd12; prev_mem[12] = 10'd7;
        rnd_ready = 1'b1;
        run_trace(7, 0, 16, 1'b1, lat);
        run_trace(7, 9, 16, 1'b0, lat);
        rnd_ready = 1'b0;

        // Reset while waiting on the interface, then a clean retrace
        prev_mem[0] = 10'd0; prev_mem[1] = 10'd0; prev_mem[2] = 10'd1; prev_mem[3] = 10'd2;
        @(negedge clock);
        source = 16'd0; destination = 16'd3; number_of_nodes = 16'd4;
        trace_start = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 100 && !hit; k++) begin
            @(negedge clock);
            trace_start = 1'b0;
            if (di_clock_enable) hit = 1'b1;
        end
        check("wait_reached", 32'(hit), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_di_ce", 32'(di_clock_enable), 32'd0);
        check("abort_valid", 32'(node_valid), 32'd0);
        reset = 1'b0;
        run_trace(0, 3, 4, 1'b0, lat);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/path_tracer.md
Name: path_tracer

Overview:
- Sits directly downstream of the Dijkstra custom-instruction interface. After a shortest-path run completes, it drives the interface in mode 3 (read previous-vector entry), one transaction per hop.
- It walks the previous vector back from the destination to the source and stores the visited nodes on an internal stack.
- It then streams the path out in source-to-destination order on a valid/ready port, for DMA or a host FIFO.

Parameters:
- MAX_NODES, 1024: maximum graph size; also the stack depth.
- INDEX_WIDTH, 10: width of a node index (log2 MAX_NODES).
- UNREACHABLE, {INDEX_WIDTH{1'b1}}: previous-vector value meaning "no predecessor".

Ports:
- clock  in  1: single clock; all logic is on posedge.
- reset  in  1: synchronous, active-high.
- trace_start  in  1: one-cycle request; sampled only in IDLE.
- source  in  16: path source node.
- destination  in  16: path destination node.
- number_of_nodes  in  16: node count of the current graph.
- busy  out  1: high in every state except IDLE.
- done  out  1: one-cycle pulse when the trace terminates, on success or error.
- error_code  out  2: 0 = ok, 1 = unreachable, 2 = loop/overflow, 3 = index out of range. Held until the next accepted trace_start.
- path_length  out  INDEX_WIDTH+1: number of nodes in the path, inclusive of both ends. Held like error_code.
- di_start  out  1: start pulse to the interface.
- di_select_n  out  8: constant 8'd3.
- di_dataa  out  32: {16'h0, current node}.
- di_datab  out  32: constant 0.
- di_clock_enable  out  1: transaction enable to the interface.
- di_result  in  32: previous-vector value; bits [INDEX_WIDTH-1:0] are used.
- di_ready  in  1: transaction complete.
- node_valid  out  1: output stream valid.
- node_index  out  16: path node, zero-extended.
- node_last  out  1: high with the final (destination) node.
- node_ready  in  1: output stream backpressure.

Behaviour:
- Reset values: busy = 0, done = 0, error_code = 0, path_length = 0, di_start = 0, di_clock_enable = 0, node_valid = 0, node_last = 0. Stack pointer = 0; state = IDLE.
- Reset mid-operation aborts immediately and gives the same values. Stack contents are don't-care.
- States: IDLE, CHECK, ISSUE, WAIT, PUSH, EMIT, FINISH.
- IDLE:
  - On trace_start, latch source, destination and number_of_nodes.
  - Set current = destination, sp = 0; clear error_code and path_length.
  - Go to CHECK.
- CHECK:
  - If source ≥ number_of_nodes, destination ≥ number_of_nodes, or number_of_nodes > MAX_NODES: error_code = 3, go to FINISH.
  - Otherwise push current (sp increments) and go to FINISH if current == source, else to ISSUE.
- ISSUE:
  - di_start = 1 for exactly one cycle. di_dataa and di_select_n are already valid this cycle.
  - Go to WAIT.
- WAIT:
  - di_clock_enable = 1; di_dataa held stable.
  - When di_ready is high, capture prev = di_result[INDEX_WIDTH-1:0] and go to PUSH.
  - No timeout.
- PUSH:
  - If prev == UNREACHABLE: error_code = 1, go to FINISH.
  - Else if prev ≥ number_of_nodes, or sp == number_of_nodes (hop count exceeds node count, i.e. a cycle): error_code = 2, go to FINISH.
  - Else push prev and set current = prev. Go to FINISH if prev == source, else to ISSUE.
- Hop cost: minimum 3 cycles (ISSUE, WAIT with one-cycle ready, PUSH).
- FINISH:
  - path_length = sp when error_code == 0, else 0.
  - done pulses in this cycle.
  - Go to EMIT if error_code == 0 and sp > 0, else to IDLE.
- EMIT:
  - node_valid = 1 and node_index = stack[sp-1]; node_last = (sp == 1).
  - On node_valid && node_ready, decrement sp. After the last node transfers, go to IDLE.
  - node_index and node_last are stable while stalled.
- Output order: node 0 is the source and the last node is the destination.
- Source == destination: path_length = 1, no interface transactions, one node emitted with node_last = 1.
- The stack is a MAX_NODES × INDEX_WIDTH synchronous RAM or register file. Its read latency must be hidden: node_valid never asserts with stale data.
- di_start is never asserted outside ISSUE; di_clock_enable is never asserted outside WAIT.
- trace_start while busy is ignored.

Test Plan:
- Chain 0→1→2→3; prev = {0, 0, 1, 2}; source = 0, destination = 3, number_of_nodes = 4 → 3 transactions. error_code = 0, path_length = 4; stream 0, 1, 2, 3 with last on 3.
- source = destination = 5, number_of_nodes = 8 → no di_start. path_length = 1; single node 5 with node_last = 1.
- prev[3] = 10'h3FF; source = 0, destination = 3 → done with error_code = 1, path_length = 0, no node_valid.
- Loop prev[2] = 3, prev[3] = 2; source = 0, destination = 3, number_of_nodes = 4 → error_code = 2 after at most 4 hops.
- destination = 9 with number_of_nodes = 4 → error_code = 3 in 2 cycles; bench toggles node_ready randomly on a valid path and checks order and stable data under stall.
- Assert reset during WAIT → next cycle busy = 0, di_clock_enable = 0. A subsequent trace succeeds normally.
